pre_addr_decode: RTL
====================

PRE_ADDR_DECODE -- requirements
Module: pre_addr_decode

Interface
REQ-001 Parameter word_num, 16: maximum words per sentence, which is the buffer depth.
REQ-002 Parameter word_num_bit, 4: width of a word index.
REQ-003 Parameter POS_num, 11: number of POS tags, which is the one-hot width.
REQ-004 Parameter POS_num_bit, 4: width of an encoded POS index.
REQ-005 clk  input  1: single clock; all state changes on its rising edge.
REQ-006 reset  input  1: asynchronous, active-low reset.
REQ-007 wr_valid  input  1: encoded backpointer present on pre_addr_Pre_addr_decode_in.
REQ-008 pre_addr_Pre_addr_decode_in  input  POS_num_bit: encoded POS index for the current word.
REQ-009 wr_ready  output  1: block can accept a write this cycle.
REQ-010 tb_start  input  1: begin traceback of the stored words.
REQ-011 out_valid  output  1: pre_addr_Pre_addr_decode_out holds a valid one-hot tag.
REQ-012 out_ready  input  1: downstream accepts the current output.
REQ-013 pre_addr_Pre_addr_decode_out  output  POS_num: one-hot decoded POS tag.
REQ-014 out_idx  output  POS_num_bit: encoded index behind the current one-hot tag.
REQ-015 out_last  output  1: current output is the final traceback word (word 0).
REQ-016 err  output  1: sticky flag for an out-of-range index.

Function
REQ-017 The FSM SHALL have three states: IDLE, FILL and DRAIN.
REQ-018 The write counter SHALL be word_num_bit+1 bits wide and range 0..word_num.
REQ-019 wr_ready SHALL equal 1 exactly when the state is not DRAIN and the count is below word_num.
- A write is accepted when wr_valid and wr_ready are both 1.
- The accepted index is stored at buf[count], and count increments.
REQ-020 The first accepted write in IDLE SHALL move the FSM to FILL.
REQ-021 In FILL, tb_start SHALL move the FSM to DRAIN on the next edge.
- A write accepted in the same cycle is stored and included in the traceback.
REQ-022 tb_start in IDLE with count 0 SHALL be ignored.
- out_valid stays 0 and the FSM stays in IDLE.
REQ-023 wr_valid asserted while wr_ready is 0 SHALL be dropped, with no state change.
- This covers buffer full and the DRAIN state.
REQ-024 In DRAIN, the outputs SHALL present the entry at buf[count-1], last-written first (LIFO).
- out_valid = 1.
- out_idx = buf[count-1].
- pre_addr_Pre_addr_decode_out = one-hot of out_idx.
REQ-025 Latency: the edge that sets DRAIN SHALL make out_valid 1 in the following cycle, with no bubble.
REQ-026 When out_valid and out_ready are both 1, count SHALL decrement and the next entry SHALL appear in the following cycle.
- When count reaches 0, the FSM returns to IDLE and out_valid drops to 0.
REQ-027 out_last SHALL be 1 exactly when the state is DRAIN and count equals 1.
REQ-028 While out_ready is 0 in DRAIN, all outputs SHALL hold stable.
REQ-029 Outside DRAIN, out_valid, pre_addr_Pre_addr_decode_out, out_idx and out_last SHALL all be 0.
REQ-030 tb_start asserted during DRAIN SHALL be ignored.

Reset
REQ-031 reset low SHALL immediately force the following, regardless of clk:
- state IDLE and count 0;
- out_valid, out_last, err, out_idx and pre_addr_Pre_addr_decode_out all 0;
- wr_ready 1.
REQ-032 Buffer contents SHALL not be reset.
REQ-033 A reset asserted mid-FILL or mid-DRAIN SHALL abandon the sentence.
- The first write after release is stored at buf[0].

Configuration
REQ-034 With PRE_ADDR_DECODE_RANGE_CHK_EN defined, a stored index of POS_num or above SHALL be reported as follows when presented:
- pre_addr_Pre_addr_decode_out = 0;
- out_idx = the raw index value;
- err set to 1, held until reset.
REQ-035 Without PRE_ADDR_DECODE_RANGE_CHK_EN, err SHALL be tied to 0.
- The one-hot output is the shift 1<<index truncated to POS_num bits.
- Out-of-range indices therefore give all zeros.

Verification
REQ-036 Write 3, 0, 10 with out_ready held 1, then pulse tb_start -> the bench SHALL observe:
- outputs 0x400, 0x001 and 0x008 on consecutive cycles;
- out_last on the third output;
- IDLE afterwards.
REQ-037 Write 16 indices, then hold wr_valid for a 17th write -> the bench SHALL observe:
- wr_ready 0 after the 16th write;
- the 17th write dropped;
- a traceback of exactly 16 outputs.
REQ-038 In DRAIN, toggle out_ready 1,0,0,1 -> the bench SHALL observe the output held during the 0 cycles and no entry skipped or repeated.
REQ-039 Assert reset low for 1 cycle during DRAIN with 5 entries remaining -> the bench SHALL observe:
- out_valid 0 immediately;
- wr_ready 1;
- a following 1-word sentence decoded correctly.
REQ-040 With the macro defined, write index 12 and drain it -> the bench SHALL observe output 0, out_idx 12, and err staying 1 until reset.
- Without the macro, err SHALL stay 0.
REQ-041 tb_start with an empty buffer, and tb_start together with wr_valid in FILL -> the bench SHALL observe:
- no output for the empty case;
- the same-cycle word emitted first.

Source files
------------

// File: rtl/pre_addr_decode.sv
// Backpointer buffer and LIFO traceback decoder: stores encoded POS indices and replays them last-first as one-hot tags.
// Optional PRE_ADDR_DECODE_RANGE_CHK_EN enables a sticky err flag for out-of-range stored indices.
module pre_addr_decode #(
    parameter int word_num     = 16,
    parameter int word_num_bit = 4,
    parameter int POS_num      = 11,
    parameter int POS_num_bit  = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   wr_valid,
    input  logic [POS_num_bit-1:0] pre_addr_Pre_addr_decode_in,
    output logic                   wr_ready,
    input  logic                   tb_start,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [POS_num-1:0]     pre_addr_Pre_addr_decode_out,
    output logic [POS_num_bit-1:0] out_idx,
    output logic                   out_last,
    output logic                   err
);

    localparam int CW = word_num_bit + 1;
    localparam logic [CW-1:0] CNT_FULL = CW'(word_num);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {IDLE, FILL, DRAIN} state_t;

    state_t                 state;
    state_t                 state_nx;
    logic [CW-1:0]          count;
    logic [CW-1:0]          count_nx;
    logic [CW-1:0]          rd_ptr;
    logic [POS_num_bit-1:0] mem [word_num];
    logic                   wr_acc;
    logic                   rd_acc;
    logic                   drain_nx;
    logic [POS_num_bit-1:0] idx_nx;
    logic [POS_num-1:0]     oh_nx;

    always_comb begin
        wr_acc   = wr_valid && wr_ready;
        rd_acc   = (state == DRAIN) && out_ready;
        state_nx = state;
        count_nx = count;
        case (state)
            IDLE: begin
                if (wr_acc) begin
                    count_nx = count + CNT_ONE;
                    state_nx = FILL;
                end
            end
            FILL: begin
                if (wr_acc) count_nx = count + CNT_ONE;
                if (tb_start) state_nx = DRAIN;
            end
            DRAIN: begin
                if (rd_acc) begin
                    count_nx = count - CNT_ONE;
                    if (count == CNT_ONE) state_nx = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
        drain_nx = (state_nx == DRAIN);

        // Outputs are registered, so the next top-of-stack is looked up here;
        // a word written on the same edge as tb_start bypasses the buffer.
        rd_ptr = count_nx - CNT_ONE;
        if (wr_acc && (rd_ptr == count))
            idx_nx = pre_addr_Pre_addr_decode_in;
        else
            idx_nx = mem[rd_ptr[word_num_bit-1:0]];

        oh_nx = '0;
        for (int unsigned i = 0; i < POS_num; i++) begin
            if (32'(idx_nx) == i) oh_nx[i] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state                        <= IDLE;
            count                        <= '0;
            out_valid                    <= 1'b0;
            out_idx                      <= '0;
            pre_addr_Pre_addr_decode_out <= '0;
            out_last                     <= 1'b0;
            wr_ready                     <= 1'b1;
        end else begin
            state                        <= state_nx;
            count                        <= count_nx;
            out_valid                    <= drain_nx;
            out_idx                      <= drain_nx ? idx_nx : '0;
            pre_addr_Pre_addr_decode_out <= drain_nx ? oh_nx : '0;
            out_last                     <= drain_nx && (count_nx == CNT_ONE);
            wr_ready                     <= !drain_nx && (count_nx < CNT_FULL);
        end
    end

    // Buffer contents intentionally survive reset.
    always_ff @(posedge clk) begin
        if (wr_acc) mem[count[word_num_bit-1:0]] <= pre_addr_Pre_addr_decode_in;
    end

`ifdef PRE_ADDR_DECODE_RANGE_CHK_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            err <= 1'b0;
        else if (drain_nx && (32'(idx_nx) >= 32'(POS_num)))
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
